// File: rtl/tea_io_mailbox_pkg.sv
// rtl/tea_io_mailbox_pkg.sv - shared constants and types for the tea_io_mailbox block
//
// Holds the default register addresses, the mailbox state encoding and the
// status register bit positions. Imported by the mailbox top and the bench.
package tea_io_mailbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mbox_state_t;

    localparam logic [4:0] DEF_STATUS_ADDR = 5'h1F;
    localparam logic [4:0] DEF_COUNT_ADDR  = 5'h1E;

    localparam int STAT_NOT_BUSY_BIT  = 0;
    localparam int STAT_OUT_VALID_BIT = 1;
    localparam int STAT_PF_FULL_BIT   = 2;

    // Extract byte idx of a 64-bit block (byte 0 in bits 7:0).
    function automatic logic [7:0] byte_of(input logic [63:0] blk, input logic [2:0] idx);
        return blk[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/tea_io_mailbox_if.sv
// rtl/tea_io_mailbox_if.sv - host stream and CPU I/O bus bundle for tea_io_mailbox
//
// Signals:
//   in_valid/in_ready/in_data     host -> mailbox 64-bit input block
//   out_valid/out_ready/out_data  mailbox -> host 64-bit result block
//   io_addr/io_rd/io_wr/io_wrdata CPU I/O access, io_rddata combinational read data
// Modports: master = host + CPU side, slave = mailbox side.
interface tea_io_mailbox_if #(
    parameter int IO_AW = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [IO_AW-1:0] io_addr;
    logic             io_rd;
    logic             io_wr;
    logic [7:0]       io_wrdata;
    logic [7:0]       io_rddata;

    modport master (
        output in_valid, in_data, out_ready, io_addr, io_rd, io_wr, io_wrdata,
        input  in_ready, out_valid, out_data, io_rddata
    );

    modport slave (
        input  in_valid, in_data, out_ready, io_addr, io_rd, io_wr, io_wrdata,
        output in_ready, out_valid, out_data, io_rddata
    );
endinterface

// File: rtl/tea_byte_reg64.sv
// rtl/tea_byte_reg64.sv - 64-bit register with whole-word load and indexed byte write
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset (clears to 0)
//   ld_en, ld_data    load all 64 bits
//   wr_en, wr_idx,    write one byte selected by wr_idx; applied after a
//   wr_byte           same-cycle load so the byte write wins
//   q                 register contents
module tea_byte_reg64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_en,
    input  logic [63:0] ld_data,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [7:0]  wr_byte,
    output logic [63:0] q
);
    logic [63:0] data_q;
    logic [63:0] data_d;

    always_comb begin
        data_d = data_q;
        if (ld_en) begin
            data_d = ld_data;
        end
        if (wr_en) begin
            data_d[{wr_idx, 3'b000} +: 8] = wr_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/tea_io_mailbox.sv
// rtl/tea_io_mailbox.sv - mailbox bridging a 64-bit host block stream to the tea_cpu I/O space
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   tea_io_mailbox_if.slave: host input/output streams and CPU I/O bus
// Register map (CPU side):
//   0x00-0x07   read: input block bytes; write (BUSY only): result bytes
//   STATUS_ADDR read: {5'b0, prefetch_full, out_valid, not_busy}; write bit0=1 in BUSY: done
//   COUNT_ADDR  read: completed-block counter
// Optional feature macro: TEA_MBOX_PREFETCH_EN (one-entry input prefetch buffer).
module tea_io_mailbox
    import tea_io_mailbox_pkg::*;
#(
    parameter int               IO_AW       = 5,
    parameter logic [IO_AW-1:0] STATUS_ADDR = IO_AW'(DEF_STATUS_ADDR),
    parameter logic [IO_AW-1:0] COUNT_ADDR  = IO_AW'(DEF_COUNT_ADDR)
) (
    input logic              clk,
    input logic              rst,
    tea_io_mailbox_if.slave  bus
);
    mbox_state_t state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  blk_cnt_q, blk_cnt_d;

    logic [63:0] in_buf;
    logic [63:0] res_buf;
    logic        in_ld_en;
    logic [63:0] in_ld_data;

    logic        in_hs;
    logic        out_hs;
    logic        busy;
    logic        addr_is_byte;
    logic        res_wr_en;
    logic        done_wr;
    logic        pf_full;
    logic [7:0]  status;

    // Read strobe carries no side effects in this block.
    logic        unused_io_rd;
    assign unused_io_rd = bus.io_rd;

`ifdef TEA_MBOX_PREFETCH_EN
    logic        pf_full_q, pf_full_d;
    logic        pf_ld_en;
    logic [63:0] pf_buf;
`endif

    assign in_hs        = bus.in_valid & in_ready_q;
    assign out_hs       = out_valid_q & bus.out_ready;
    assign busy         = (state_q == ST_BUSY);
    assign addr_is_byte = (bus.io_addr[IO_AW-1:3] == '0);
    // Byte and done writes only land while the CPU owns a block, which keeps
    // out_data frozen while it is being offered to the host.
    assign res_wr_en    = busy & bus.io_wr & addr_is_byte;
    assign done_wr      = busy & bus.io_wr & (bus.io_addr == STATUS_ADDR) & bus.io_wrdata[0];

`ifdef TEA_MBOX_PREFETCH_EN
    assign pf_full = pf_full_q;
`else
    assign pf_full = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        blk_cnt_d  = blk_cnt_q;
        in_ld_en   = 1'b0;
        in_ld_data = bus.in_data;
`ifdef TEA_MBOX_PREFETCH_EN
        pf_full_d  = pf_full_q;
        pf_ld_en   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    in_ld_en = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done_wr) begin
                    state_d = ST_DONE;
                end
`ifdef TEA_MBOX_PREFETCH_EN
                if (in_hs) begin
                    pf_ld_en  = 1'b1;
                    pf_full_d = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (out_hs) begin
                    blk_cnt_d = blk_cnt_q + 8'd1;
                    state_d   = ST_IDLE;
`ifdef TEA_MBOX_PREFETCH_EN
                    // Next block is already waiting: skip IDLE entirely.
                    if (pf_full_q) begin
                        in_ld_en   = 1'b1;
                        in_ld_data = pf_buf;
                        pf_full_d  = 1'b0;
                        state_d    = ST_BUSY;
                    end else if (in_hs) begin
                        in_ld_en = 1'b1;
                        state_d  = ST_BUSY;
                    end
`endif
                end
`ifdef TEA_MBOX_PREFETCH_EN
                else if (in_hs) begin
                    pf_ld_en  = 1'b1;
                    pf_full_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_DONE);
`ifdef TEA_MBOX_PREFETCH_EN
        in_ready_d  = (state_d == ST_IDLE) | ~pf_full_d;
`else
        in_ready_d  = (state_d == ST_IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            blk_cnt_q   <= 8'h00;
`ifdef TEA_MBOX_PREFETCH_EN
            pf_full_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            blk_cnt_q   <= blk_cnt_d;
`ifdef TEA_MBOX_PREFETCH_EN
            pf_full_q   <= pf_full_d;
`endif
        end
    end

    tea_byte_reg64 u_in_buf (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (in_ld_en),
        .ld_data (in_ld_data),
        .wr_en   (1'b0),
        .wr_idx  (3'd0),
        .wr_byte (8'h00),
        .q       (in_buf)
    );

    tea_byte_reg64 u_res_buf (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (1'b0),
        .ld_data (64'h0),
        .wr_en   (res_wr_en),
        .wr_idx  (bus.io_addr[2:0]),
        .wr_byte (bus.io_wrdata),
        .q       (res_buf)
    );

`ifdef TEA_MBOX_PREFETCH_EN
    tea_byte_reg64 u_pf_buf (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (pf_ld_en),
        .ld_data (bus.in_data),
        .wr_en   (1'b0),
        .wr_idx  (3'd0),
        .wr_byte (8'h00),
        .q       (pf_buf)
    );
`endif

    always_comb begin
        status                     = 8'h00;
        status[STAT_NOT_BUSY_BIT]  = ~busy;
        status[STAT_OUT_VALID_BIT] = out_valid_q;
        status[STAT_PF_FULL_BIT]   = pf_full;
    end

    always_comb begin
        bus.io_rddata = 8'h00;
        if (addr_is_byte) begin
            bus.io_rddata = byte_of(in_buf, bus.io_addr[2:0]);
        end else if (bus.io_addr == STATUS_ADDR) begin
            bus.io_rddata = status;
        end else if (bus.io_addr == COUNT_ADDR) begin
            bus.io_rddata = blk_cnt_q;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = res_buf;

endmodule
